// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data.
// Define MEM_ARB_ROUND_ROBIN_EN to replace starvation-bounded data priority with round robin.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_own_f;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        w_pick_f;
    logic        w_gnt_f;
    logic        w_gnt_d;
    logic        w_rv_f;
    logic        w_rv_d;
    logic        w_unused;

    // Word fetches only: the byte offset of the fetch address is dropped.
    assign w_unused = &{1'b0, if_addr[1:0]};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_f;

    assign w_pick_f = if_req && (!d_req || !r_last_f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_f <= 1'b1;
        end else if (w_gnt_f || w_gnt_d) begin
            r_last_f <= w_gnt_f;
        end
    end
`else
    logic [3:0] r_starve;

    assign w_pick_f = if_req && (!d_req || (r_starve == 4'(STARVE_MAX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 4'd0;
        end else if (w_gnt_f) begin
            r_starve <= 4'd0;
        end else if (w_gnt_d && if_req) begin
            r_starve <= r_starve + 4'd1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_f     = 1'b0;
        w_gnt_d     = 1'b0;
        w_rv_f      = 1'b0;
        w_rv_d      = 1'b0;
        mem_req     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // Readys are combinational, so hold them off while in reset.
                if (rst_n && (if_req || d_req)) begin
                    w_gnt_f     = w_pick_f;
                    w_gnt_d     = !w_pick_f;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_rv_f      = r_own_f;
                    w_rv_d      = !r_own_f;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own_f <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_gnt_f) begin
            r_own_f <= 1'b1;
            r_we    <= 1'b0;
            r_be    <= 4'hF;
            r_addr  <= {if_addr[31:2], 2'b00};
            r_wdata <= 32'd0;
        end else if (w_gnt_d) begin
            r_own_f <= 1'b0;
            r_we    <= d_we;
            r_be    <= d_be;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (mem_rvalid && (r_state != ST_WAIT)) begin
            r_err <= 1'b1;
        end
    end

    assign if_ready  = w_gnt_f;
    assign d_ready   = w_gnt_d;
    assign if_rvalid = w_rv_f;
    assign d_rvalid  = w_rv_d;
    assign if_rdata  = w_rv_f ? mem_rdata : 32'd0;
    assign d_rdata   = w_rv_d ? mem_rdata : 32'd0;
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule
